// File: rtl/pipe_ctrl_pkg.sv
// Shared stage indices, sequencer states and stall/flush patterns for the core pipeline control.
// Pure definitions; no logic, latency or flow control of its own.
package pipe_ctrl_pkg;

  localparam int NUM_STG = 5;
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2
  } state_e;

  localparam logic [NUM_STG-1:0] STALL_NONE = 5'b00000;
  localparam logic [NUM_STG-1:0] STALL_ALL  = 5'b11111;
  localparam logic [NUM_STG-1:0] STALL_DIV  = 5'b01111;
  localparam logic [NUM_STG-1:0] STALL_LU   = 5'b00111;

  localparam logic [NUM_STG-1:0] FLUSH_NONE = 5'b00000;
  localparam logic [NUM_STG-1:0] FLUSH_ALL  = 5'b11111;
  localparam logic [NUM_STG-1:0] FLUSH_DIV  = 5'b10000;
  localparam logic [NUM_STG-1:0] FLUSH_JMP  = 5'b00110;
  localparam logic [NUM_STG-1:0] FLUSH_LU   = 5'b01000;

endpackage

// File: rtl/pipe_load_use_det.sv
// Load-use detector: flags an ID read of the register an EX-stage load is about to write.
// Purely combinational, zero latency; no flow control.
module pipe_load_use_det (
  input  logic [4:0] i_rs1,
  input  logic       i_rs1_re,
  input  logic [4:0] i_rs2,
  input  logic       i_rs2_re,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_we,
  input  logic       i_ex_load,
  output logic       o_lu
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_rs1_re && (i_rs1 == i_ex_rd);
  assign w_rs2_hit = i_rs2_re && (i_rs2 == i_ex_rd);

  // x0 is hard-wired, so a load targeting it never creates a dependency
  assign o_lu = i_ex_load && i_ex_we && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: combinational stall/flush/redirect from registered state; state and counters update each cycle.
// Holds the pipeline through bus wait states and divides; bus watchdog raises a one-cycle error pulse.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         id_reg1_raddr_i,
  input  logic [4:0]         id_reg2_raddr_i,
  input  logic               id_reg1_RE_i,
  input  logic               id_reg2_RE_i,
  input  logic [4:0]         ex_reg_waddr_i,
  input  logic               ex_reg_we_i,
  input  logic               ex_mem_rd_i,
  input  logic               ex_jump_i,
  input  logic [31:0]        ex_jump_addr_i,
  input  logic               ex_div_start_i,
  input  logic               div_ready_i,
  input  logic               mem_req_i,
  input  logic               mem_ready_i,
  output logic [NUM_STG-1:0] ctrl_stall_o,
  output logic [NUM_STG-1:0] ctrl_flush_o,
  output logic               ctrl_jump_o,
  output logic [31:0]        ctrl_jump_addr_o,
  output logic               ctrl_bus_err_o,
  output logic [CNT_W-1:0]   ctrl_stall_cnt_o
);

  localparam int            TW        = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TCNT_LAST = TW'(MEM_TIMEOUT - 1);

  state_e             r_state;
  logic [TW-1:0]      r_tcnt;
  logic [CNT_W-1:0]   r_cnt;

  state_e             w_nxt;
  logic [TW-1:0]      w_tcnt_nxt;
  logic [NUM_STG-1:0] w_stall;
  logic [NUM_STG-1:0] w_flush;
  logic               w_jump;
  logic               w_err;
  logic               w_run_eval;
  logic               w_lu;

  pipe_load_use_det u_lu (
    .i_rs1     (id_reg1_raddr_i),
    .i_rs1_re  (id_reg1_RE_i),
    .i_rs2     (id_reg2_raddr_i),
    .i_rs2_re  (id_reg2_RE_i),
    .i_ex_rd   (ex_reg_waddr_i),
    .i_ex_we   (ex_reg_we_i),
    .i_ex_load (ex_mem_rd_i),
    .o_lu      (w_lu)
  );

  always_comb begin
    w_nxt      = S_RUN;
    w_tcnt_nxt = r_tcnt;
    w_stall    = STALL_NONE;
    w_flush    = FLUSH_NONE;
    w_jump     = 1'b0;
    w_err      = 1'b0;
    w_run_eval = 1'b0;

    case (r_state)
      S_MEM_WAIT: begin
        if (mem_ready_i) begin
          w_run_eval = 1'b1;
        end else if (r_tcnt == TCNT_LAST) begin
          w_err   = 1'b1;
          w_flush = FLUSH_ALL;
        end else begin
          w_stall    = STALL_ALL;
          w_tcnt_nxt = r_tcnt + TW'(1);
          w_nxt      = S_MEM_WAIT;
        end
      end
      S_DIV_WAIT: begin
        if (!div_ready_i) begin
          w_stall = STALL_DIV;
          w_flush = FLUSH_DIV;
          w_nxt   = S_DIV_WAIT;
        end else begin
          // a jump frozen in EX behind the divide issues now, once
          w_jump = ex_jump_i;
        end
      end
      default: begin
        if (mem_req_i && !mem_ready_i) begin
          w_stall    = STALL_ALL;
          w_tcnt_nxt = '0;
          w_nxt      = S_MEM_WAIT;
        end else begin
          w_run_eval = 1'b1;
        end
      end
    endcase

    if (w_run_eval) begin
      if (ex_div_start_i) begin
        w_stall = STALL_DIV;
        w_flush = FLUSH_DIV;
        w_nxt   = S_DIV_WAIT;
      end else if (ex_jump_i) begin
        w_flush = FLUSH_JMP;
        w_jump  = 1'b1;
      end else if (w_lu) begin
        w_stall = STALL_LU;
        w_flush = FLUSH_LU;
      end
    end
  end

  assign ctrl_stall_o     = rst ? STALL_NONE : w_stall;
  assign ctrl_flush_o     = rst ? FLUSH_NONE : w_flush;
  assign ctrl_jump_o      = !rst && w_jump && !w_stall[STG_PC];
  assign ctrl_jump_addr_o = ctrl_jump_o ? ex_jump_addr_i : 32'd0;
  assign ctrl_bus_err_o   = !rst && w_err;
  assign ctrl_stall_cnt_o = rst ? '0 : r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_tcnt  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_tcnt  <= w_tcnt_nxt;
      if (w_stall[STG_PC] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core. It consumes ID read-port info, the EX load/jump/divide status, and the MEM data-bus handshake.
- Drives per-stage stall and flush vectors, the PC redirect, a memory-wait watchdog and a stall performance counter.
- Covers the hazards that operand forwarding cannot resolve: load-use, multi-cycle divide, bus wait states and control transfer.

Parameters:
MEM_TIMEOUT, 255, max S_MEM_WAIT cycles before bus error (must be ≥ 2)
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_reg1_raddr_i  in  5  ID source reg 1
id_reg2_raddr_i  in  5  ID source reg 2
id_reg1_RE_i  in  1  ID reads reg 1
id_reg2_RE_i  in  1  ID reads reg 2
ex_reg_waddr_i  in  5  EX destination reg
ex_reg_we_i  in  1  EX writes register
ex_mem_rd_i  in  1  EX instruction is a load
ex_jump_i  in  1  EX resolved taken branch/jump
ex_jump_addr_i  in  32  redirect target
ex_div_start_i  in  1  EX holds a divide needing the divider
div_ready_i  in  1  divider result valid
mem_req_i  in  1  MEM data-bus request
mem_ready_i  in  1  data-bus ready
ctrl_stall_o  out  5  hold stage: [0]PC [1]IF [2]ID [3]EX [4]MEM
ctrl_flush_o  out  5  bubble into stage register, same bit map
ctrl_jump_o  out  1  PC redirect
ctrl_jump_addr_o  out  32  redirect target
ctrl_bus_err_o  out  1  one-cycle bus timeout pulse
ctrl_stall_cnt_o  out  CNT_W  cycles with ctrl_stall_o[0]=1

Behaviour:
- Reset: state S_RUN, timeout counter 0, stall counter 0. While rst=1 every output is 0.
- Stall/flush/jump outputs are combinational from the current state and inputs. State and counters are registered.
- Load-use condition (lu): ex_mem_rd_i & ex_reg_we_i & ex_reg_waddr_i≠0 & ((id_reg1_RE_i & id_reg1_raddr_i==ex_reg_waddr_i) | (id_reg2_RE_i & id_reg2_raddr_i==ex_reg_waddr_i)).
- S_RUN priority, highest first:
  - mem_req_i & !mem_ready_i: stall=11111, flush=0. Next state S_MEM_WAIT, tcnt←0.
  - ex_div_start_i: stall=01111, flush=10000. Next state S_DIV_WAIT.
  - ex_jump_i: stall=0, flush=00110, ctrl_jump_o=1, addr=ex_jump_addr_i. A simultaneous lu is ignored.
  - lu: stall=00111, flush=01000. This is a one-cycle bubble; lu self-clears as the load advances.
  - mem_req_i & mem_ready_i (zero wait) adds nothing.
- S_MEM_WAIT:
  - mem_ready_i=0: stall=11111, tcnt+1.
  - mem_ready_i=1: stall=0 that same cycle; evaluate the S_RUN rules except the mem rule. Next state S_RUN.
  - tcnt==MEM_TIMEOUT-1 & !mem_ready_i: ctrl_bus_err_o=1, flush=11111, stall=0. Next state S_RUN.
- S_DIV_WAIT:
  - div_ready_i=0: stall=01111, flush=10000.
  - div_ready_i=1: stall=0, flush=0. Next state S_RUN; the divide result advances from EX.
  - A jump in EX waits: ex_jump_i persists in the frozen EX stage and issues on release.
- ctrl_jump_o is asserted only in cycles where ctrl_stall_o[0]=0, so a frozen jump issues exactly once.
- ctrl_stall_cnt_o increments when ctrl_stall_o[0]=1 and saturates at all-ones (no wrap).
- Reset mid-wait: abandon the state at once; no error pulse.
- Unknown or illegal state: treat as S_RUN.

Decomposition:
- Package pipe_ctrl_pkg:
  - stage bit indices STG_PC..STG_MEM and NUM_STG=5
  - state enum S_RUN/S_MEM_WAIT/S_DIV_WAIT
  - stall/flush pattern constants (e.g. STALL_ALL=11111, STALL_DIV=01111, STALL_LU=00111)
- Sub-module pipe_load_use_det: combinational lu detector, reusable by the ID-stage forwarding logic.

Test Plan:
- lu bubble: EX load, ex_reg_waddr=5; ID reads reg1=5 with RE=1 → one cycle stall=00111, flush=01000, then 0. Repeat with id_reg1_raddr=0 → no stall.
- Jump + lu together: ex_jump_i=1, addr=0x8000_0100, and lu true → ctrl_jump_o=1, addr=0x80000100, flush=00110, stall=0.
- Mem wait: mem_req=1 with ready low for 3 cycles, then high → stall=11111 for 3 cycles, 0 on the ready cycle; stall_cnt advances by 3.
- Timeout with MEM_TIMEOUT=4: ready never rises → stall for cycles 1-3; cycle 4 gives bus_err=1, flush=11111; cycle 5 is back in S_RUN.
- Divide + pending jump: div_start with ex_jump_i held, div_ready after 5 cycles → stall=01111 and flush=10000 for 5 cycles; single ctrl_jump_o pulse in the release cycle.
- Reset during S_MEM_WAIT → next cycle all outputs 0, counter 0, no bus_err.
